// File: rtl/cache_sa_pkg.sv
// Shared definitions for the set-associative cache: controller states,
// bus widths and the way-index width helper.
package cache_sa_pkg;

  localparam int unsigned WORD_W  = 32;   // processor word
  localparam int unsigned BLOCK_W = 128;  // memory block, four words
  localparam int unsigned PADDR_W = 30;   // processor word address
  localparam int unsigned BADDR_W = 28;   // memory block address
  localparam int unsigned OFF_W   = 2;    // word-in-block offset

  typedef enum logic [1:0] {
    ST_COMPARE   = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  // Way index width; a direct-mapped build still carries a 1-bit index.
  function automatic int unsigned way_w(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_lru_set.sv
// True-LRU age vector for one set. Each way holds an age; 0 is most recently
// used, WAYS-1 is the replacement candidate.
// Ports: clk, rst_n (async, active-low), access/access_way (touch a way),
//        victim (way whose age is WAYS-1).
module cache_lru_set
  import cache_sa_pkg::*;
#(
  parameter int unsigned WAYS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     access,
  input  logic [way_w(WAYS)-1:0]   access_way,
  output logic [way_w(WAYS)-1:0]   victim
);

  localparam int unsigned WAY_W = way_w(WAYS);

  if (WAYS == 1) begin : g_dm
    // Single way: there is nothing to order, the only way is always the victim.
    logic unused_dm;
    assign unused_dm = ^{clk, rst_n, access, access_way};
    assign victim    = '0;
  end else begin : g_lru
    logic [WAY_W-1:0] age_q [WAYS];
    logic [WAY_W-1:0] acc_age;

    assign acc_age = age_q[access_way];

    // Touched way becomes youngest; only ways younger than it age by one,
    // which keeps the ages a permutation of 0..WAYS-1.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int w = 0; w < WAYS; w++) age_q[w] <= WAY_W'(w);
      end else if (access) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == access_way)  age_q[w] <= '0;
          else if (age_q[w] < acc_age)  age_q[w] <= age_q[w] + 1'b1;
        end
      end
    end

    always_comb begin
      victim = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/cache_sa.sv
// N-way set-associative, write-back, write-allocate cache between a 32-bit
// processor word port and a 128-bit block memory port.
// Ports: clk, proc_reset_n (async, active-low);
//        processor side proc_read/proc_write/proc_addr/proc_wdata in,
//        proc_rdata/proc_stall out (combinational response);
//        memory side mem_read/mem_write/mem_addr/mem_wdata out (registered),
//        mem_rdata/mem_ready in.
module cache_sa
  import cache_sa_pkg::*;
#(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 4
) (
  input  logic                 clk,
  input  logic                 proc_reset_n,
  input  logic                 proc_read,
  input  logic                 proc_write,
  input  logic [PADDR_W-1:0]   proc_addr,
  output logic [WORD_W-1:0]    proc_rdata,
  input  logic [WORD_W-1:0]    proc_wdata,
  output logic                 proc_stall,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [BADDR_W-1:0]   mem_addr,
  input  logic [BLOCK_W-1:0]   mem_rdata,
  output logic [BLOCK_W-1:0]   mem_wdata,
  input  logic                 mem_ready
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = BADDR_W - IDX_W;
  localparam int unsigned WAY_W = way_w(WAYS);

  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [BLOCK_W-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-1:0]    dirty_q [SETS];

  state_t             state_q;
  logic [BADDR_W-1:0] miss_blk_q;
  logic [WAY_W-1:0]   victim_q;
  logic [WAY_W-1:0]   lru_victim [SETS];

  // Request address fields
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [6:0]       word_lsb;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;

  assign req_tag  = proc_addr[PADDR_W-1 -: TAG_W];
  assign req_idx  = proc_addr[OFF_W +: IDX_W];
  assign word_lsb = {proc_addr[OFF_W-1:0], 5'd0};
  assign miss_tag = miss_blk_q[BADDR_W-1 -: TAG_W];
  assign miss_idx = miss_blk_q[IDX_W-1:0];

  // Tag compare across the indexed set
  logic             hit;
  logic [WAY_W-1:0] hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  logic req, in_cmp, cmp_hit, cmp_miss, fill;

  assign req      = proc_read | proc_write;
  assign in_cmp   = (state_q == ST_COMPARE);
  assign cmp_hit  = in_cmp & req & hit;
  assign cmp_miss = in_cmp & req & ~hit;
  assign fill     = (state_q == ST_ALLOCATE) & mem_ready;

  assign proc_stall = req & ~(in_cmp & hit);
  assign proc_rdata = (in_cmp && proc_read && hit)
                    ? data_q[req_idx][hit_way][word_lsb +: WORD_W] : '0;

  // Victim: lowest-index invalid way, otherwise the set's oldest way
  logic [WAY_W-1:0] victim_c;
  logic             victim_dirty;

  always_comb begin
    victim_c = lru_victim[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim_c = WAY_W'(w);
    end
  end

  assign victim_dirty = valid_q[req_idx][victim_c] & dirty_q[req_idx][victim_c];

  // Controller: miss handling and memory bus handshake
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q    <= ST_COMPARE;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      miss_blk_q <= '0;
      victim_q   <= '0;
    end else begin
      case (state_q)
        ST_COMPARE: begin
          if (cmp_miss) begin
            miss_blk_q <= proc_addr[PADDR_W-1:OFF_W];
            victim_q   <= victim_c;
            if (victim_dirty) begin
              state_q   <= ST_WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {tag_q[req_idx][victim_c], req_idx};
              mem_wdata <= data_q[req_idx][victim_c];
            end else begin
              state_q  <= ST_ALLOCATE;
              mem_read <= 1'b1;
              mem_addr <= proc_addr[PADDR_W-1:OFF_W];
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ready) begin
            state_q   <= ST_ALLOCATE;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= miss_blk_q;
          end
        end
        ST_ALLOCATE: begin
          if (mem_ready) begin
            state_q  <= ST_COMPARE;
            mem_read <= 1'b0;
          end
        end
        default: state_q <= ST_COMPARE;
      endcase
    end
  end

  // Line status: reset invalidates everything
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else if (fill) begin
      valid_q[miss_idx][victim_q] <= 1'b1;
      dirty_q[miss_idx][victim_q] <= 1'b0;
    end else if (cmp_hit && proc_write) begin
      dirty_q[req_idx][hit_way] <= 1'b1;
    end
  end

  // Tag and data storage, qualified by valid so no reset needed
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[miss_idx][victim_q] <= mem_rdata;
      tag_q[miss_idx][victim_q]  <= miss_tag;
    end else if (cmp_hit && proc_write) begin
      data_q[req_idx][hit_way][word_lsb +: WORD_W] <= proc_wdata;
    end
  end

  // Replacement state; hits and refills both count as accesses
  logic             lru_acc;
  logic [IDX_W-1:0] lru_idx;
  logic [WAY_W-1:0] lru_way;

  assign lru_acc = cmp_hit | fill;
  assign lru_idx = fill ? miss_idx : req_idx;
  assign lru_way = fill ? victim_q : hit_way;

  for (genvar s = 0; s < SETS; s++) begin : g_set
    cache_lru_set #(.WAYS(WAYS)) u_lru (
      .clk        (clk),
      .rst_n      (proc_reset_n),
      .access     (lru_acc && (lru_idx == IDX_W'(s))),
      .access_way (lru_way),
      .victim     (lru_victim[s])
    );
  end

endmodule

// File: tb/tb_cache_sa.sv
// Directed bench for cache_sa: a 2-way/4-set instance against a delay-
// programmable block memory, plus a direct-mapped (WAYS=1) instance.
module tb_cache_sa;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         proc_reset_n;
  logic         proc_read, proc_write, proc_stall;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_rdata, proc_wdata;
  logic         mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata, mem_wdata;

  logic         d1_read, d1_write, d1_stall;
  logic [29:0]  d1_addr;
  logic [31:0]  d1_rdata, d1_wdata;
  logic         d1_mem_read, d1_mem_write, d1_mem_ready;
  logic [27:0]  d1_mem_addr;
  logic [127:0] d1_mem_rdata, d1_mem_wdata;

  cache_sa #(.WAYS(2), .SETS(4)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
    .proc_rdata(proc_rdata), .proc_wdata(proc_wdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_ready(mem_ready)
  );

  cache_sa #(.WAYS(1), .SETS(4)) dut1 (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .proc_read(d1_read), .proc_write(d1_write), .proc_addr(d1_addr),
    .proc_rdata(d1_rdata), .proc_wdata(d1_wdata), .proc_stall(d1_stall),
    .mem_read(d1_mem_read), .mem_write(d1_mem_write), .mem_addr(d1_mem_addr),
    .mem_rdata(d1_mem_rdata), .mem_wdata(d1_mem_wdata), .mem_ready(d1_mem_ready)
  );

  typedef struct {
    bit          wr;
    logic [27:0] addr;
    logic [31:0] w0;
  } op_t;

  int           checks = 0;
  int           errors = 0;
  int           mem_delay = 2;
  bit           overlap_seen = 1'b0;
  logic [127:0] mem_model [64];
  logic [31:0]  ref_word [256];
  op_t          op_log [$];

  // Memory word k initially holds 0x1000_0000 + k
  function automatic logic [127:0] init_block(input logic [27:0] b);
    logic [31:0] base;
    base = 32'h1000_0000 + 32'({b, 2'b00});
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Block memory for the 2-way instance: answers mem_delay cycles late
  initial begin : mem_resp
    int cnt;
    op_t op;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_read && mem_write) overlap_seen = 1'b1;
      if (mem_read || mem_write) begin
        if (cnt >= mem_delay) begin
          cnt = 0;
          mem_ready = 1'b1;
          op.wr = mem_write;
          op.addr = mem_addr;
          op.w0 = mem_wdata[31:0];
          if (mem_write) mem_model[mem_addr[5:0]] = mem_wdata;
          else           mem_rdata = mem_model[mem_addr[5:0]];
          op_log.push_back(op);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Zero-delay read-only memory for the direct-mapped instance
  initial begin : mem_resp1
    d1_mem_ready = 1'b0;
    d1_mem_rdata = '0;
    forever begin
      @(negedge clk);
      d1_mem_ready = 1'b0;
      if (d1_mem_read || d1_mem_write) begin
        d1_mem_ready = 1'b1;
        d1_mem_rdata = init_block(d1_mem_addr);
      end
    end
  end

  task automatic access(input bit wr, input logic [29:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int stalls);
    bit done;
    stalls = 0;
    rd = '0;
    done = 1'b0;
    @(posedge clk); #1;
    proc_addr = addr; proc_wdata = wd; proc_read = !wr; proc_write = wr;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!proc_stall) begin
        done = 1'b1;
        rd = proc_rdata;
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $error("FAIL timeout: access %0h still stalled after 200 cycles", addr);
    end
    if (wr) ref_word[addr[7:0]] = wd;
    @(posedge clk); #1;
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  task automatic access1(input logic [29:0] addr, output logic [31:0] rd, output int stalls);
    bit done;
    stalls = 0;
    rd = '0;
    done = 1'b0;
    @(posedge clk); #1;
    d1_addr = addr; d1_read = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (!d1_stall) begin
        done = 1'b1;
        rd = d1_rdata;
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $error("FAIL timeout_dm: access %0h still stalled after 50 cycles", addr);
    end
    @(posedge clk); #1;
    d1_read = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] rd;
    int          st;
    int          n0;
    bit          seen;
    logic [29:0] a;
    logic [31:0] wd;
    bit          wr;

    for (int b = 0; b < 64; b++) mem_model[b] = init_block(28'(b));
    for (int k = 0; k < 256; k++) ref_word[k] = 32'h1000_0000 + 32'(k);

    proc_reset_n = 1'b0;
    proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    d1_read = 1'b0; d1_write = 1'b0; d1_addr = '0; d1_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(proc_stall), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_rdata", proc_rdata, 32'd0);
    check("rst_dm_mem_read", 32'(d1_mem_read), 32'd0);
    @(posedge clk); #1;
    proc_reset_n = 1'b1;

    // Cold miss then a hit in the same block
    mem_delay = 2;
    access(1'b0, 30'h000, '0, rd, st);
    check("cold_stall", st, 32'd4);
    check("cold_rdata", rd, 32'h1000_0000);
    check("cold_ops", op_log.size(), 32'd1);
    check("cold_op_is_read", 32'(op_log[0].wr), 32'd0);
    n0 = op_log.size();
    access(1'b0, 30'h001, '0, rd, st);
    check("hit_stall", st, 32'd0);
    check("hit_rdata", rd, 32'h1000_0001);
    check("hit_no_traffic", op_log.size(), n0);

    // LRU eviction in set 0
    access(1'b0, 30'h010, '0, rd, st);
    check("s0_b_stall", st, 32'd4);
    check("s0_b_rdata", rd, 32'h1000_0010);
    access(1'b0, 30'h020, '0, rd, st);
    check("s0_c_stall", st, 32'd4);
    check("s0_c_rdata", rd, 32'h1000_0020);
    access(1'b0, 30'h010, '0, rd, st);
    check("s0_b_rehit", st, 32'd0);
    access(1'b0, 30'h000, '0, rd, st);
    check("s0_a_evicted", st, 32'd4);
    check("s0_a_rdata", rd, 32'h1000_0000);

    // Dirty line forced out of set 1
    access(1'b1, 30'h004, 32'hDEAD_BEEF, rd, st);
    check("wmiss_stall", st, 32'd4);
    access(1'b0, 30'h014, '0, rd, st);
    check("s1_b_stall", st, 32'd4);
    check("s1_b_rdata", rd, 32'h1000_0014);
    access(1'b0, 30'h024, '0, rd, st);
    check("wb_stall", st, 32'd7);
    check("wb_rdata", rd, 32'h1000_0024);
    check("wb_op_write", 32'(op_log[op_log.size()-2].wr), 32'd1);
    check("wb_addr", 32'(op_log[op_log.size()-2].addr), 32'h0000001);
    check("wb_wdata", op_log[op_log.size()-2].w0, 32'hDEAD_BEEF);
    check("wb_then_read", 32'(op_log[op_log.size()-1].wr), 32'd0);
    check("wb_then_read_addr", 32'(op_log[op_log.size()-1].addr), 32'h0000009);
    access(1'b0, 30'h004, '0, rd, st);
    check("wb_refetch_stall", st, 32'd4);
    check("wb_refetch_rdata", rd, 32'hDEAD_BEEF);
    access(1'b1, 30'h005, 32'h1234_5678, rd, st);
    check("whit_stall", st, 32'd0);
    access(1'b0, 30'h005, '0, rd, st);
    check("whit_read_stall", st, 32'd0);
    check("whit_read_rdata", rd, 32'h1234_5678);

    // Random traffic with random memory latency
    for (int i = 0; i < 300; i++) begin
      mem_delay = int'($urandom_range(0, 7));
      a  = 30'($urandom_range(0, 63));
      wd = $urandom;
      wr = 1'($urandom_range(0, 1));
      if (!wr) wd = ref_word[a[7:0]];
      access(wr, a, wd, rd, st);
      check("rand_stall_shape",
            32'((st == 0) || (st == mem_delay + 2) || (st == 2 * mem_delay + 3)), 32'd1);
      if (!wr) check("rand_rdata", rd, wd);
    end
    check("no_rd_wr_overlap", 32'(overlap_seen), 32'd0);

    // Reset while a refill is outstanding
    mem_delay = 7;
    @(posedge clk); #1;
    proc_addr = 30'h0C0; proc_read = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (mem_read) seen = 1'b1;
    end
    check("abort_reached_allocate", 32'(seen), 32'd1);
    proc_reset_n = 1'b0;
    #1;
    check("abort_mem_read", 32'(mem_read), 32'd0);
    check("abort_mem_write", 32'(mem_write), 32'd0);
    check("abort_rdata", proc_rdata, 32'd0);
    proc_read = 1'b0;
    @(posedge clk); #1;
    proc_reset_n = 1'b1;
    mem_delay = 2;
    access(1'b0, 30'h001, '0, rd, st);
    check("post_rst_miss_a", st, 32'd4);
    access(1'b0, 30'h001, '0, rd, st);
    check("post_rst_hit_a", st, 32'd0);
    n0 = op_log.size();
    access(1'b0, 30'h005, '0, rd, st);
    check("post_rst_miss_b", st, 32'd4);
    check("post_rst_no_wb", op_log.size(), n0 + 1);

    // Direct-mapped build: conflicting blocks always miss
    access1(30'h000, rd, st);
    check("dm_a_stall", st, 32'd2);
    check("dm_a_rdata", rd, 32'h1000_0000);
    access1(30'h001, rd, st);
    check("dm_a_hit", st, 32'd0);
    check("dm_a_hit_rdata", rd, 32'h1000_0001);
    access1(30'h010, rd, st);
    check("dm_b_stall", st, 32'd2);
    check("dm_b_rdata", rd, 32'h1000_0010);
    access1(30'h000, rd, st);
    check("dm_a_again", st, 32'd2);
    access1(30'h010, rd, st);
    check("dm_b_again", st, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
